ardisik_toplayici: RTL and testbench

- Parametrised multi-cycle adder/subtractor; successor to the team's single-cycle 64-bit behavioural adder.
- Processes operands CHUNK bits per clock, carrying between chunks, so wide adds close timing at high clock rates.
- Valid/ready handshakes on input and output. Sits between the operand register file and the result collector.

---
 rtl/toplayici_pkg.sv | 14 +
 rtl/parca_toplayici.sv | 15 +
 rtl/ardisik_toplayici.sv | 114 +++++++++++
 tb/tb_ardisik_toplayici.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toplayici_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM encoding and
// default operand/chunk widths.
package toplayici_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CHUNK = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/parca_toplayici.sv
// Combinational CHUNK-bit adder with carry in/out; the top reuses one
// instance for every chunk of an operation.
module parca_toplayici #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/ardisik_toplayici.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, rippling the
// carry through a register, with valid/ready handshakes on both sides.
module ardisik_toplayici
  import toplayici_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] number1,
  input  logic [WIDTH-1:0] number2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("ardisik_toplayici: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH:0]   sum_q;
  logic             ovf_q;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
  logic             chunk_c;
  logic             last;

  assign last    = (idx_q == LAST_IDX);
  assign chunk_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign chunk_b = b_q[int'(idx_q)*CHUNK +: CHUNK];

  parca_toplayici #(.CHUNK(CHUNK)) u_parca (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_c)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Subtraction is A + ~B + 1: the inverted operand is latched and the +1
  // enters as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= number1;
            b_q     <= sub ? ~number2 : number2;
            carry_q <= sub;
            idx_q   <= '0;
          end
        end
        CALC: begin
          sum_q[int'(idx_q)*CHUNK +: CHUNK] <= chunk_s;
          carry_q <= chunk_c;
          if (last) begin
            sum_q[WIDTH] <= chunk_c;
            ovf_q        <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                            (chunk_s[CHUNK-1] != a_q[WIDTH-1]);
            idx_q        <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ardisik_toplayici.sv
// Self-checking bench: scoreboarded default-size instance plus 32/8 and
// 64/64 instances for latency, value and mid-operation reset checks.
module tb_ardisik_toplayici;

  localparam int W  = 64;
  localparam int C  = 16;
  localparam int N  = W / C;
  localparam int W2 = 32;
  localparam int C2 = 8;
  localparam int W3 = 64;
  localparam int C3 = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-size instance
  logic          in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic          in_ready, out_valid, ovf;
  logic [W-1:0]  number1 = '0, number2 = '0;
  logic [W:0]    sum;

  ardisik_toplayici #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sub(sub), .number1(number1), .number2(number2), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .ovf(ovf)
  );

  // WIDTH=32, CHUNK=8 instance
  logic          b_in_valid = 1'b0, b_sub = 1'b0, b_out_ready = 1'b1;
  logic          b_in_ready, b_out_valid, b_ovf;
  logic [W2-1:0] b_number1 = '0, b_number2 = '0;
  logic [W2:0]   b_sum;

  ardisik_toplayici #(.WIDTH(W2), .CHUNK(C2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sub(b_sub), .number1(b_number1), .number2(b_number2), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .sum(b_sum), .ovf(b_ovf)
  );

  // CHUNK=WIDTH instance
  logic          c_in_valid = 1'b0, c_sub = 1'b0, c_out_ready = 1'b1;
  logic          c_in_ready, c_out_valid, c_ovf;
  logic [W3-1:0] c_number1 = '0, c_number2 = '0;
  logic [W3:0]   c_sum;

  ardisik_toplayici #(.WIDTH(W3), .CHUNK(C3)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .sub(c_sub), .number1(c_number1), .number2(c_number2), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .sum(c_sum), .ovf(c_ovf)
  );

  typedef struct packed {
    logic [W:0] sum;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 65-bit arithmetic, independent of chunking.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t       e;
    logic [W-1:0] bp;
    bp    = s ? ~b : b;
    e.sum = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, s};
    e.ovf = (a[W-1] == bp[W-1]) && (e.sum[W-1] != a[W-1]);
    return e;
  endfunction

  // Output side of the scoreboard: a result transfers on the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("sum", sum, e.sum);
        check("ovf", ovf, e.ovf);
      end
    end
  end

  task automatic wait_ready();
    int i;
    for (i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    check("in_ready_wait", in_ready, 1'b1);
  endtask

  // Accept one operation, scramble the inputs afterwards, check latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W:0] es, input logic eo);
    int lat;
    exp_t e;
    @(posedge clk); #1;
    wait_ready();
    number1 = a; number2 = b; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; number1 = ~a; number2 = ~b; sub = ~s;
    e.sum = es;
    e.ovf = eo;
    sb.push_back(e);
    check("in_ready_calc", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, N);
  endtask

  task automatic run_rand(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    e = model(a, b, s);
    run_op(a, b, s, e.sum, e.ovf);
  endtask

  task automatic op_b(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic s,
                      input logic [W2:0] es, input logic eo);
    int lat;
    @(posedge clk); #1;
    for (int i = 0; i < 20 && !b_in_ready; i++) begin
      @(posedge clk); #1;
    end
    b_number1 = a; b_number2 = b; b_sub = s; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_number1 = '0; b_number2 = '1;
    lat = 0;
    while (!b_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b_latency", lat, 4);
    check("b_sum", b_sum, es);
    check("b_ovf", b_ovf, eo);
  endtask

  task automatic op_c(input logic [W3-1:0] a, input logic [W3-1:0] b, input logic s,
                      input logic [W3:0] es, input logic eo);
    int lat;
    @(posedge clk); #1;
    for (int i = 0; i < 20 && !c_in_ready; i++) begin
      @(posedge clk); #1;
    end
    c_number1 = a; c_number2 = b; c_sub = s; c_in_valid = 1'b1;
    @(posedge clk); #1;
    c_in_valid = 1'b0; c_number1 = '0; c_number2 = '1;
    lat = 0;
    while (!c_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("c_latency", lat, 1);
    check("c_sum", c_sum, es);
    check("c_ovf", c_ovf, eo);
  endtask

  // After a mid-operation reset, watch that no result ever shows up.
  task automatic release_and_watch(input string tag);
    int seen;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid || b_out_valid || c_out_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] held;
    int i;

    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_ovf", ovf, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic adds and legacy vectors
    run_op(64'd1,  64'd1,  1'b0, 65'd2,  1'b0);
    run_op(64'd1,  64'd50, 1'b0, 65'd51, 1'b0);
    run_op(64'd15, 64'd30, 1'b0, 65'd45, 1'b0);
    run_op(64'd25, 64'd52, 1'b0, 65'd77, 1'b0);
    run_op(64'd60, 64'd17, 1'b0, 65'd77, 1'b0);

    // Carry chain
    run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 65'h0_0000_0000_0001_0000, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 65'h1_0000_0000_0000_0000, 1'b0);

    // Subtract
    run_op(64'd5, 64'd7, 1'b1, 65'h0_FFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op(64'd7, 64'd5, 1'b1, 65'h1_0000_0000_0000_0002, 1'b0);

    // Signed overflow
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 65'h0_8000_0000_0000_0000, 1'b1);
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 65'h1_7FFF_FFFF_FFFF_FFFF, 1'b1);

    // Random operands against the reference model
    for (i = 0; i < 6; i++)
      run_rand({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));

    // Backpressure: result held, second request ignored
    @(posedge clk); #1;
    wait_ready();
    out_ready = 1'b0;
    number1 = 64'd100; number2 = 64'd23; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(model(64'd100, 64'd23, 1'b0));
    for (i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp_valid_rise", out_valid, 1'b1);
    held = sum;
    check("bp_sum_value", held, 65'd123);
    number1 = 64'd999; number2 = 64'd1; in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_sum_stable", sum, held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", in_ready, 1'b1);
    run_op(64'd40, 64'd2, 1'b0, 65'd42, 1'b0);

    // Reset mid-CALC, default instance
    @(posedge clk); #1;
    wait_ready();
    number1 = 64'd3; number2 = 64'd4; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_sum", sum, '0);
    release_and_watch("mid_rst_no_result");

    // WIDTH=32, CHUNK=8
    op_b(32'hFFFF_FFFF, 32'd1, 1'b0, 33'h1_0000_0000, 1'b0);
    op_b(32'h7FFF_FFFF, 32'd1, 1'b0, 33'h0_8000_0000, 1'b1);
    op_b(32'd10, 32'd3, 1'b1, 33'h1_0000_0007, 1'b0);
    @(posedge clk); #1;
    b_number1 = 32'd8; b_number2 = 32'd9; b_sub = 1'b0; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("b_rst_out_valid", b_out_valid, 1'b0);
    check("b_rst_in_ready", b_in_ready, 1'b1);
    check("b_rst_sum", b_sum, '0);
    release_and_watch("b_rst_no_result");

    // CHUNK=WIDTH: a single CALC cycle
    op_c(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 65'h1_0000_0000_0000_0000, 1'b0);
    op_c(64'd5, 64'd7, 1'b1, 65'h0_FFFF_FFFF_FFFF_FFFE, 1'b0);
    @(posedge clk); #1;
    c_number1 = 64'd8; c_number2 = 64'd9; c_sub = 1'b0; c_in_valid = 1'b1;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    check("c_in_calc", c_in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("c_rst_out_valid", c_out_valid, 1'b0);
    check("c_rst_in_ready", c_in_ready, 1'b1);
    check("c_rst_sum", c_sum, '0);
    release_and_watch("c_rst_no_result");

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
